bc_input_port: RTL and testbench

Input-device side of the basic computer's FGI/INPR handshake: receives asynchronous serial bytes (8N1, LSB first) on a single line and presents each byte on INPR. It raises FGI when a byte is ready and holds INPR stable until the CPU's INP instruction acknowledges it. The block sits between the external pin and the BC_I top, where it drives the CPU's FGI input and INPR bus.

---
 rtl/bc_io_pkg.sv | 24 ++
 rtl/bc_sync2.sv | 30 +++
 rtl/bc_input_port.sv | 192 +++++++++++++++++++
 tb/tb_bc_input_port.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bc_io_pkg.sv
// Shared definitions for the basic computer serial I/O ports.
// Holds the receiver FSM state encoding, the default bit period and the
// 8N1 frame constants. Imported by bc_input_port and later by the output port.
package bc_io_pkg;

  // Receiver FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
  } rx_state_e;

  // Default number of clk cycles per serial bit.
  localparam int BC_CLKS_PER_BIT = 16;

  // 8N1 frame: one start bit (0), eight data bits LSB first, one stop bit (1).
  localparam int   BC_DATA_BITS   = 8;
  localparam logic BC_IDLE_LEVEL  = 1'b1;
  localparam logic BC_START_LEVEL = 1'b0;
  localparam logic BC_STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/bc_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
// Both flops reset to 1 so an idle-high line reads idle straight out of reset.
// Ports:
//   clk   - system clock
//   rst_n - asynchronous active-low reset
//   d_i   - asynchronous input
//   q_o   - synchronized output, two cycles behind d_i
module bc_sync2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b1;
      sync_q <= 1'b1;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/bc_input_port.sv
// Input-device side of the basic computer FGI/INPR handshake.
// Receives 8N1 serial frames (LSB first) on rx_serial, presents each byte on
// INPR and raises FGI until the CPU's INP instruction acknowledges it.
// Ports:
//   clk       - system clock, all state rising-edge
//   rst_n     - asynchronous active-low reset
//   rx_serial - asynchronous serial line, idle high
//   inp_ack   - one-cycle pulse when INP executes; clears FGI and error flags
//   FGI       - 1 while INPR holds an unread byte
//   INPR      - received byte, updated only when a byte is delivered
//   overrun   - sticky: a byte completed while FGI=1 and was dropped
//   frame_err - sticky: a stop bit was sampled as 0
//   state_o   - current receiver FSM state (debug visibility)
// Handshake: FGI is a level flag owned by this block; inp_ack is a single-cycle
// acknowledge from the CPU. A byte arriving on the same cycle as inp_ack is
// delivered (FGI stays 1) and is not an overrun.
module bc_input_port
  import bc_io_pkg::*;
#(
  parameter int CLKS_PER_BIT = BC_CLKS_PER_BIT,
  parameter int DATA_BITS    = BC_DATA_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 rx_serial,
  input  logic                 inp_ack,
  output logic                 FGI,
  output logic [DATA_BITS-1:0] INPR,
  output logic                 overrun,
  output logic                 frame_err,
  output logic [2:0]           state_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  // Last count of a full bit period, and of the half period used to land
  // the start-bit check in the middle of the start bit.
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  logic rx_s;

  rx_state_e            state_q,     state_d;
  logic [CW-1:0]        clk_cnt_q,   clk_cnt_d;
  logic [BW-1:0]        bit_cnt_q,   bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q,     shift_d;
  logic [DATA_BITS-1:0] inpr_q,      inpr_d;
  logic                 fgi_q,       fgi_d;
  logic                 overrun_q,   overrun_d;
  logic                 frame_err_q, frame_err_d;

  logic stop_good;
  logic stop_bad;

  bc_sync2 u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (rx_serial),
    .q_o   (rx_s)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      clk_cnt_q   <= '0;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      inpr_q      <= '0;
      fgi_q       <= 1'b0;
      overrun_q   <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_cnt_q   <= clk_cnt_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      inpr_q      <= inpr_d;
      fgi_q       <= fgi_d;
      overrun_q   <= overrun_d;
      frame_err_q <= frame_err_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    clk_cnt_d   = clk_cnt_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    inpr_d      = inpr_q;
    fgi_d       = fgi_q;
    overrun_d   = overrun_q;
    frame_err_d = frame_err_q;
    stop_good   = 1'b0;
    stop_bad    = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (rx_s == BC_START_LEVEL) begin
          clk_cnt_d = '0;
          state_d   = START;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          if (rx_s != BC_START_LEVEL) begin
            // Line went back high before mid-start-bit: glitch, ignore it.
            state_d = IDLE;
          end else begin
            clk_cnt_d = '0;
            bit_cnt_d = '0;
            state_d   = DATA;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d          = '0;
          shift_d[bit_cnt_q] = rx_s;
          if (bit_cnt_q == BIT_LAST) begin
            state_d = STOP;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      STOP: begin
        if (clk_cnt_q == CLK_LAST) begin
          clk_cnt_d = '0;
          if (rx_s == BC_STOP_LEVEL) begin
            stop_good = 1'b1;
            state_d   = IDLE;
          end else begin
            stop_bad = 1'b1;
            state_d  = WAIT_HIGH;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CW'(1);
        end
      end

      WAIT_HIGH: begin
        // Hold off until the line returns idle so a break is not read as
        // a stream of start bits.
        if (rx_s == BC_IDLE_LEVEL) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    if (inp_ack) begin
      fgi_d       = 1'b0;
      overrun_d   = 1'b0;
      frame_err_d = 1'b0;
    end

    // Delivery overrides the ack's FGI clear; an ack on the same cycle
    // frees the slot so the new byte is accepted rather than dropped.
    if (stop_good) begin
      if (!fgi_q || inp_ack) begin
        inpr_d = shift_q;
        fgi_d  = 1'b1;
      end else begin
        overrun_d = 1'b1;
      end
    end

    // A frame error wins over a simultaneous ack.
    if (stop_bad) begin
      frame_err_d = 1'b1;
    end
  end

  assign FGI       = fgi_q;
  assign INPR      = inpr_q;
  assign overrun   = overrun_q;
  assign frame_err = frame_err_q;
  assign state_o   = state_q;

endmodule

// File: tb/tb_bc_input_port.sv
module tb_bc_input_port;
  import bc_io_pkg::*;

  localparam int CPB = 16;
  localparam int DB  = 8;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_serial = 1'b1;
  logic          inp_ack = 1'b0;
  logic          FGI;
  logic [DB-1:0] INPR;
  logic          overrun;
  logic          frame_err;
  logic [2:0]    state_o;

  always #5 clk = ~clk;

  bc_input_port #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_serial (rx_serial),
    .inp_ack   (inp_ack),
    .FGI       (FGI),
    .INPR      (INPR),
    .overrun   (overrun),
    .frame_err (frame_err),
    .state_o   (state_o)
  );

  int cyc = 0;
  always @(posedge clk) cyc++;

  // Cycle number of the most recent FGI rising edge.
  int   fgi_rise_cyc = -1;
  logic fgi_prev = 1'b0;
  always @(negedge clk) begin
    if (FGI === 1'b1 && fgi_prev !== 1'b1) fgi_rise_cyc = cyc;
    fgi_prev = FGI;
  end

  initial begin
    #(10 * 60000);
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model / scoreboard ----------------
  int checks = 0;
  int failures = 0;

  logic [DB-1:0] exp_q[$];   // bytes accepted into INPR, newest last
  bit            m_fgi;
  bit            m_ovr;
  bit            m_ferr;

  function automatic logic [DB-1:0] m_inpr();
    if (exp_q.size() == 0) return '0;
    return exp_q[$];
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_fgi  = 0;
    m_ovr  = 0;
    m_ferr = 0;
  endfunction

  function automatic void model_ack();
    m_fgi  = 0;
    m_ovr  = 0;
    m_ferr = 0;
  endfunction

  // One completed frame; ack_same means inp_ack landed on its stop sample.
  function automatic void model_frame(logic [DB-1:0] d, bit stop_ok, bit ack_same);
    bit was_full;
    was_full = m_fgi;
    if (ack_same) model_ack();
    if (!stop_ok) begin
      m_ferr = 1;
    end else if (!was_full || ack_same) begin
      exp_q.push_back(d);
      m_fgi = 1;
    end else begin
      m_ovr = 1;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag);
    chk({tag, ".fgi"},       32'(FGI),       32'(m_fgi));
    chk({tag, ".inpr"},      32'(INPR),      32'(m_inpr()));
    chk({tag, ".overrun"},   32'(overrun),   32'(m_ovr));
    chk({tag, ".frame_err"}, 32'(frame_err), 32'(m_ferr));
  endtask

  // ---------------- driver tasks (called at a negedge) ----------------
  task automatic send_byte(input logic [DB-1:0] d, input logic stop_bit, input bit ack_early);
    rx_serial = 1'b0;
    if (ack_early) inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
    repeat (CPB - 1) @(negedge clk);
    for (int i = 0; i < DB; i++) begin
      rx_serial = d[i];
      repeat (CPB) @(negedge clk);
    end
    rx_serial = stop_bit;
    repeat (CPB) @(negedge clk);
  endtask

  task automatic pulse_ack();
    inp_ack = 1'b1;
    @(negedge clk);
    inp_ack = 1'b0;
  endtask

  task automatic idle_bits(input int n);
    rx_serial = 1'b1;
    repeat (n * CPB) @(negedge clk);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int        t0;
    int        lat;
    bit        saw_start;
    bit        hit_stop;
    logic [DB-1:0] d;
    bit        ok;
    bit        ack_e;

    model_reset();
    repeat (3) @(negedge clk);
    chk_all("reset");
    chk("reset.state", 32'(state_o), 32'(IDLE));
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 1: single byte, FGI latency roughly (DB+1.5)*CPB after the start edge
    t0 = cyc;
    send_byte(8'hA5, 1'b1, 0);
    model_frame(8'hA5, 1, 0);
    chk_all("t1");
    lat = fgi_rise_cyc - t0;
    chk("t1.latency_window", 32'(lat >= 145 && lat <= 170), 32'd1);
    idle_bits(1);

    // 2: overrun while holding an unread byte, then ack
    pulse_ack(); model_ack();
    send_byte(8'h3C, 1'b1, 0); model_frame(8'h3C, 1, 0);
    idle_bits(1);
    send_byte(8'h7E, 1'b1, 0); model_frame(8'h7E, 1, 0);
    chk_all("t2.overrun");
    pulse_ack(); model_ack();
    chk_all("t2.ack");
    idle_bits(1);

    // 3: bad stop bit followed by a long break
    send_byte(8'h55, 1'b0, 0); model_frame(8'h55, 0, 0);
    repeat (40 * CPB) @(negedge clk);
    chk_all("t3.break");
    chk("t3.state", 32'(state_o), 32'(WAIT_HIGH));
    idle_bits(2);
    chk_all("t3.release");
    pulse_ack(); model_ack();
    chk_all("t3.ack");
    send_byte(8'h12, 1'b1, 0); model_frame(8'h12, 1, 0);
    chk_all("t3.recover");
    idle_bits(1);

    // 4: short low glitch on an idle line must be rejected
    saw_start = 0;
    rx_serial = 1'b0;
    repeat (3) @(negedge clk);
    rx_serial = 1'b1;
    for (int i = 0; i < 12; i++) begin
      if (state_o == START) saw_start = 1;
      @(negedge clk);
    end
    chk("t4.saw_start", 32'(saw_start), 32'd1);
    chk("t4.state", 32'(state_o), 32'(IDLE));
    chk_all("t4");

    // 5: ack exactly on the stop-sample cycle while FGI=1
    hit_stop = 0;
    fork
      send_byte(8'h81, 1'b1, 0);
      begin
        for (int i = 0; i < 400 && !hit_stop; i++) begin
          @(negedge clk);
          if (state_o == STOP) hit_stop = 1;
        end
        if (hit_stop) begin
          // Stop sample is CLKS_PER_BIT cycles after entering STOP.
          repeat (CPB - 1) @(negedge clk);
          inp_ack = 1'b1;
          @(negedge clk);
          inp_ack = 1'b0;
        end
      end
    join
    chk("t5.reached_stop", 32'(hit_stop), 32'd1);
    model_frame(8'h81, 1, 1);
    chk_all("t5");
    idle_bits(1);

    // 6: reset in the middle of a frame
    rx_serial = 1'b0;
    repeat (CPB) @(negedge clk);
    rx_serial = 1'b0; repeat (CPB) @(negedge clk);
    rx_serial = 1'b0; repeat (CPB) @(negedge clk);
    rx_serial = 1'b0; repeat (CPB / 2) @(negedge clk);
    rst_n = 1'b0;
    rx_serial = 1'b1;
    #1;
    model_reset();
    chk_all("t6.reset");
    chk("t6.state", 32'(state_o), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    idle_bits(1);
    send_byte(8'h0F, 1'b1, 0); model_frame(8'h0F, 1, 0);
    chk_all("t6.after");
    idle_bits(1);

    // Back-to-back frames, each acked during the next start bit
    for (int k = 0; k < 4; k++) begin
      d = 8'($urandom);
      ack_e = (k > 0) || m_fgi;
      if (ack_e) model_ack();
      send_byte(d, 1'b1, ack_e);
      model_frame(d, 1, 0);
      chk_all($sformatf("b2b%0d", k));
    end
    idle_bits(1);

    // Random frames with occasional bad stop bits and random acks
    for (int k = 0; k < 12; k++) begin
      d  = 8'($urandom);
      ok = ($urandom_range(0, 5) != 0);
      send_byte(d, ok, 0);
      model_frame(d, ok, 0);
      chk_all($sformatf("rnd%0d", k));
      rx_serial = 1'b1;
      repeat ($urandom_range(1, 2) * CPB) @(negedge clk);
      if ($urandom_range(0, 1) == 1) begin
        pulse_ack(); model_ack();
        chk_all($sformatf("rnd%0d.ack", k));
      end
      idle_bits(1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
